// File: rtl/ntt_sched_if.sv
// Host/BFU-side bundle of the NTT sequencer: command strobe in, status,
// read/twiddle addresses and write-back addresses out.
interface ntt_sched_if #(
    parameter int LOGN = 8
);
    logic            start;
    logic [1:0]      op;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr0;
    logic [LOGN-1:0] rd_addr1;
    logic [LOGN-1:0] tw_addr;
    logic [1:0]      bfu_mode;
    logic            wr_en0;
    logic [LOGN-1:0] wr_addr0;
    logic            wr_en1;
    logic [LOGN-1:0] wr_addr1;

    modport master (
        output start, op,
        input  busy, done, rd_en, rd_addr0, rd_addr1, tw_addr, bfu_mode,
        input  wr_en0, wr_addr0, wr_en1, wr_addr1
    );

    modport slave (
        input  start, op,
        output busy, done, rd_en, rd_addr0, rd_addr1, tw_addr, bfu_mode,
        output wr_en0, wr_addr0, wr_en1, wr_addr1
    );
endinterface

// File: rtl/ntt_sched.sv
// Address sequencer for an in-place Cooley-Tukey NTT or elementwise pass over
// an N-point memory, with write-back addresses replayed after the BFU latency.
module ntt_sched #(
    parameter int LOGN    = 8,
    parameter int BFU_LAT = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    ntt_sched_if.slave bus
);
    localparam int LAT = BFU_LAT + 1;
    localparam int SW  = $clog2(LOGN);
    localparam int CW  = $clog2(LAT + 1);

    localparam logic [LOGN-1:0] ONE        = LOGN'(1);
    localparam logic [LOGN-1:0] HALF_LAST  = LOGN'((1 << (LOGN - 1)) - 1);
    localparam logic [LOGN-1:0] FULL_LAST  = {LOGN{1'b1}};
    localparam logic [SW-1:0]   LAST_STAGE = SW'(LOGN - 1);
    localparam logic [CW-1:0]   DRAIN_LAST = CW'(LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      r_mode;
    logic [SW-1:0]   r_s;
    logic [LOGN-1:0] r_k;
    logic [CW-1:0]   r_cnt;

    logic            r_pv  [LAT];
    logic [LOGN-1:0] r_pa0 [LAT];
    logic [LOGN-1:0] r_pa1 [LAT];

    logic [SW-1:0]   w_sh;
    logic [LOGN-1:0] w_d;
    logic [LOGN-1:0] w_g;
    logic [LOGN-1:0] w_ntt0;
    logic [LOGN-1:0] w_ntt1;
    logic [LOGN-1:0] w_ntt_tw;
    logic            w_last_k;
    logic            w_rd_en;
    logic [LOGN-1:0] w_rd_addr0;
    logic [LOGN-1:0] w_rd_addr1;
    logic [LOGN-1:0] w_tw_addr;

    // Butterfly span d is a power of two, so k/d and k mod d reduce to a shift
    // and a mask; addr0 is k with a zero bit inserted at position log2(d).
    always_comb begin
        w_sh     = LAST_STAGE - r_s;
        w_d      = ONE << w_sh;
        w_g      = r_k >> w_sh;
        w_ntt0   = ((w_g << w_sh) << 1) | (r_k & (w_d - ONE));
        w_ntt1   = w_ntt0 | w_d;
        w_ntt_tw = (ONE << r_s) + w_g;
        w_last_k = r_mode[1] ? (r_k == FULL_LAST) : (r_k == HALF_LAST);

        w_rd_en    = (r_state == S_RUN);
        w_rd_addr0 = '0;
        w_rd_addr1 = '0;
        w_tw_addr  = '0;
        if (w_rd_en) begin
            if (r_mode[1]) begin
                w_rd_addr0 = r_k;
                w_rd_addr1 = r_k;
            end else begin
                w_rd_addr0 = w_ntt0;
                w_rd_addr1 = w_ntt1;
                w_tw_addr  = w_ntt_tw;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= '0;
            r_s     <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mode  <= bus.op;
                        r_s     <= '0;
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_k <= r_k + ONE;
                    if (w_last_k) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last write of a stage lands in the final drain cycle,
                    // so the next stage may start reading right after it.
                    if (r_cnt == DRAIN_LAST) begin
                        if (!r_mode[1] && (r_s != LAST_STAGE)) begin
                            r_s     <= r_s + SW'(1);
                            r_k     <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write-address replay line: one RAM read cycle plus the BFU latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_pv[i]  <= 1'b0;
                r_pa0[i] <= '0;
                r_pa1[i] <= '0;
            end
        end else begin
            r_pv[0]  <= w_rd_en;
            r_pa0[0] <= w_rd_addr0;
            r_pa1[0] <= w_rd_addr1;
            for (int i = 1; i < LAT; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pa0[i] <= r_pa0[i-1];
                r_pa1[i] <= r_pa1[i-1];
            end
        end
    end

    assign bus.busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.rd_en    = w_rd_en;
    assign bus.rd_addr0 = w_rd_addr0;
    assign bus.rd_addr1 = w_rd_addr1;
    assign bus.tw_addr  = w_tw_addr;
    assign bus.bfu_mode = r_mode;
    assign bus.wr_en0   = r_pv[LAT-1];
    assign bus.wr_en1   = r_pv[LAT-1] & ~r_mode[1];
    assign bus.wr_addr0 = r_pa0[LAT-1];
    assign bus.wr_addr1 = r_pa1[LAT-1];
endmodule

// File: tb/tb_ntt_sched.sv
// Directed bench for ntt_sched (N=8, LAT=15): address/strobe traces against
// hand-computed tables, plus a BFU+RAM model compared with a software NTT.
module tb_ntt_sched;
    localparam int LOGN    = 3;
    localparam int BFU_LAT = 14;
    localparam int LAT     = BFU_LAT + 1;
    localparam int NPTS    = 8;
    localparam int Q       = 12289;
    localparam int TRACE   = 80;

    typedef struct {
        int cyc;
        int a0;
        int a1;
        int tw;
    } rdVec_t;

    logic clk;
    logic rst_n;

    ntt_sched_if #(.LOGN(LOGN)) bus ();

    ntt_sched #(.LOGN(LOGN), .BFU_LAT(BFU_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int nChecks;
    int nFails;

    int trRd [TRACE+1];
    int trBusy [TRACE+1];
    int trDone [TRACE+1];
    int trA0 [TRACE+1];
    int trA1 [TRACE+1];
    int trTw [TRACE+1];
    int trMode [TRACE+1];
    int trWe0 [TRACE+1];
    int trWe1 [TRACE+1];
    int trWa0 [TRACE+1];
    int trWa1 [TRACE+1];

    int mem [NPTS];
    int golden [NPTS];
    int zeta [NPTS];
    int pend0 [TRACE+LAT+1];
    int pend1 [TRACE+LAT+1];

    rdVec_t nttVec [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int c, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s cyc=%0d got=%0d expected=%0d", name, c, act, exp);
        end
    endtask

    function automatic bit inWin(input int c, input int s0, input int s1, input int s2, input int w);
        return (c >= s0 && c < s0 + w) || (c >= s1 && c < s1 + w) || (c >= s2 && c < s2 + w);
    endfunction

    function automatic int modPow(input int b, input int e);
        longint r;
        longint x;
        r = 1;
        x = longint'(b);
        for (int i = 0; i < e; i++) r = (r * x) % Q;
        return int'(r);
    endfunction

    function automatic int bitRev3(input int i);
        int v;
        v = i;
        return (v[0] ? 4 : 0) + (v[1] ? 2 : 0) + (v[2] ? 1 : 0);
    endfunction

    // Textbook iterative CT loop; the zeta index walks 1..N-1 in order.
    task automatic swNtt();
        int k;
        k = 1;
        for (int len = NPTS / 2; len >= 1; len = len / 2) begin
            for (int st = 0; st < NPTS; st += 2 * len) begin
                int z;
                z = zeta[k];
                k++;
                for (int j = st; j < st + len; j++) begin
                    int t;
                    t = (z * golden[j+len]) % Q;
                    golden[j+len] = (golden[j] - t + Q) % Q;
                    golden[j] = (golden[j] + t) % Q;
                end
            end
        end
    endtask

    // Optionally starts a command in cycle 0, then records outputs of cycles
    // 1..TRACE; injKind 1 pulses start, 2 pulses rst_n low at cycle injCyc.
    task automatic applyStimulus(input bit doStart, input logic [1:0] cmdOp, input int injCyc,
                                 input int injKind, input logic [1:0] injOp, input int injLen,
                                 input bit modelOn);
        @(negedge clk);
        if (doStart) begin
            bus.start = 1'b1;
            bus.op    = cmdOp;
        end
        for (int c = 1; c <= TRACE; c++) begin
            @(negedge clk);
            trRd[c]   = int'(bus.rd_en);
            trBusy[c] = int'(bus.busy);
            trDone[c] = int'(bus.done);
            trA0[c]   = int'(bus.rd_addr0);
            trA1[c]   = int'(bus.rd_addr1);
            trTw[c]   = int'(bus.tw_addr);
            trMode[c] = int'(bus.bfu_mode);
            trWe0[c]  = int'(bus.wr_en0);
            trWe1[c]  = int'(bus.wr_en1);
            trWa0[c]  = int'(bus.wr_addr0);
            trWa1[c]  = int'(bus.wr_addr1);
            if (c == 1) bus.start = 1'b0;
            if (modelOn) begin
                if (bus.rd_en) begin
                    int u;
                    int t;
                    u = mem[int'(bus.rd_addr0)];
                    t = (zeta[int'(bus.tw_addr)] * mem[int'(bus.rd_addr1)]) % Q;
                    pend0[c+LAT] = (u + t) % Q;
                    pend1[c+LAT] = (u - t + Q) % Q;
                end
                if (bus.wr_en0) mem[int'(bus.wr_addr0)] = pend0[c];
                if (bus.wr_en1) mem[int'(bus.wr_addr1)] = pend1[c];
            end
            if (c == injCyc) begin
                if (injKind == 1) begin
                    bus.start = 1'b1;
                    bus.op    = injOp;
                end else if (injKind == 2) begin
                    rst_n = 1'b0;
                end
            end
            if (c == injCyc + injLen) begin
                bus.start = 1'b0;
                rst_n     = 1'b1;
            end
        end
    endtask

    task automatic checkNttTrace(input int expMode);
        for (int i = 0; i < 12; i++) begin
            int c;
            c = nttVec[i].cyc;
            checkOutput("rd_addr0", c, trA0[c], nttVec[i].a0);
            checkOutput("rd_addr1", c, trA1[c], nttVec[i].a1);
            checkOutput("tw_addr", c, trTw[c], nttVec[i].tw);
            checkOutput("wr_addr0", c + LAT, trWa0[c+LAT], nttVec[i].a0);
            checkOutput("wr_addr1", c + LAT, trWa1[c+LAT], nttVec[i].a1);
        end
        for (int c = 1; c <= 58; c++) begin
            checkOutput("rd_en", c, trRd[c], int'(inWin(c, 1, 20, 39, 4)));
            checkOutput("wr_en0", c, trWe0[c], int'(inWin(c, 16, 35, 54, 4)));
            checkOutput("wr_en1", c, trWe1[c], int'(inWin(c, 16, 35, 54, 4)));
            checkOutput("busy", c, trBusy[c], int'(c <= 57));
            checkOutput("done", c, trDone[c], int'(c == 58));
            checkOutput("bfu_mode", c, trMode[c], expMode);
        end
    endtask

    initial begin
        int doneCyc;
        nChecks   = 0;
        nFails    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;

        nttVec[0]  = '{1, 0, 4, 1};
        nttVec[1]  = '{2, 1, 5, 1};
        nttVec[2]  = '{3, 2, 6, 1};
        nttVec[3]  = '{4, 3, 7, 1};
        nttVec[4]  = '{20, 0, 2, 2};
        nttVec[5]  = '{21, 1, 3, 2};
        nttVec[6]  = '{22, 4, 6, 3};
        nttVec[7]  = '{23, 5, 7, 3};
        nttVec[8]  = '{39, 0, 1, 4};
        nttVec[9]  = '{40, 2, 3, 5};
        nttVec[10] = '{41, 4, 5, 6};
        nttVec[11] = '{42, 6, 7, 7};

        for (int i = 0; i < NPTS; i++) zeta[i] = modPow(modPow(11, (Q - 1) / 16), bitRev3(i));
        mem[0] = 5;    mem[1] = 1234; mem[2] = 12288; mem[3] = 7;
        mem[4] = 0;    mem[5] = 4096; mem[6] = 999;   mem[7] = 31;
        for (int i = 0; i < NPTS; i++) golden[i] = mem[i];
        swNtt();
        for (int i = 0; i < TRACE + LAT + 1; i++) begin
            pend0[i] = 0;
            pend1[i] = 0;
        end

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 0, int'(bus.busy), 0);
        checkOutput("rst_done", 0, int'(bus.done), 0);
        checkOutput("rst_rd_en", 0, int'(bus.rd_en), 0);
        checkOutput("rst_rd_addr0", 0, int'(bus.rd_addr0), 0);
        checkOutput("rst_rd_addr1", 0, int'(bus.rd_addr1), 0);
        checkOutput("rst_tw_addr", 0, int'(bus.tw_addr), 0);
        checkOutput("rst_bfu_mode", 0, int'(bus.bfu_mode), 0);
        checkOutput("rst_wr_en0", 0, int'(bus.wr_en0), 0);
        checkOutput("rst_wr_en1", 0, int'(bus.wr_en1), 0);
        checkOutput("rst_wr_addr0", 0, int'(bus.wr_addr0), 0);
        checkOutput("rst_wr_addr1", 0, int'(bus.wr_addr1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] NTT address sequence with BFU/RAM model");
        applyStimulus(1'b1, 2'b00, -100, 0, 2'b00, 1, 1'b1);
        checkNttTrace(0);
        for (int i = 0; i < NPTS; i++) checkOutput("ntt_data", i, mem[i], golden[i]);

        $display("[TB] elementwise multiply");
        applyStimulus(1'b1, 2'b11, -100, 0, 2'b00, 1, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            checkOutput("ew_rd_en", c, trRd[c], int'(c >= 1 && c <= 8));
            if (c <= 8) begin
                checkOutput("ew_rd_addr0", c, trA0[c], c - 1);
                checkOutput("ew_rd_addr1", c, trA1[c], c - 1);
                checkOutput("ew_tw_addr", c, trTw[c], 0);
            end
            checkOutput("ew_wr_en0", c, trWe0[c], int'(c >= 16 && c <= 23));
            if (c >= 16 && c <= 23) checkOutput("ew_wr_addr0", c, trWa0[c], c - 16);
            checkOutput("ew_wr_en1", c, trWe1[c], 0);
            checkOutput("ew_busy", c, trBusy[c], int'(c <= 23));
            checkOutput("ew_done", c, trDone[c], int'(c == 24));
            checkOutput("ew_bfu_mode", c, trMode[c], 3);
        end

        $display("[TB] start while busy");
        applyStimulus(1'b1, 2'b00, 10, 1, 2'b10, 1, 1'b0);
        checkNttTrace(0);
        for (int c = 59; c <= TRACE; c++) begin
            checkOutput("busy_ignore_rd_en", c, trRd[c], 0);
            checkOutput("busy_ignore_busy", c, trBusy[c], 0);
        end

        $display("[TB] reset mid-stage");
        applyStimulus(1'b1, 2'b00, 25, 2, 2'b00, 1, 1'b0);
        checkOutput("mid_busy_before", 25, trBusy[25], 1);
        checkOutput("mid_rst_busy", 26, trBusy[26], 0);
        checkOutput("mid_rst_done", 26, trDone[26], 0);
        checkOutput("mid_rst_rd_en", 26, trRd[26], 0);
        checkOutput("mid_rst_rd_addr0", 26, trA0[26], 0);
        checkOutput("mid_rst_rd_addr1", 26, trA1[26], 0);
        checkOutput("mid_rst_tw_addr", 26, trTw[26], 0);
        checkOutput("mid_rst_bfu_mode", 26, trMode[26], 0);
        checkOutput("mid_rst_wr_addr0", 26, trWa0[26], 0);
        checkOutput("mid_rst_wr_addr1", 26, trWa1[26], 0);
        for (int c = 26; c <= TRACE; c++) begin
            checkOutput("mid_rst_wr_en0", c, trWe0[c], 0);
            checkOutput("mid_rst_wr_en1", c, trWe1[c], 0);
            checkOutput("mid_rst_idle", c, trBusy[c], 0);
        end
        applyStimulus(1'b1, 2'b00, -100, 0, 2'b00, 1, 1'b0);
        checkNttTrace(0);

        $display("[TB] back-to-back commands");
        applyStimulus(1'b1, 2'b00, 58, 1, 2'b00, 2, 1'b0);
        checkOutput("b2b_done", 58, trDone[58], 1);
        checkOutput("b2b_rd_en_ignored", 59, trRd[59], 0);
        checkOutput("b2b_busy_idle", 59, trBusy[59], 0);
        checkOutput("b2b_rd_en", 60, trRd[60], 1);
        checkOutput("b2b_rd_addr0", 60, trA0[60], 0);
        checkOutput("b2b_rd_addr1", 60, trA1[60], 4);
        checkOutput("b2b_tw_addr", 60, trTw[60], 1);
        doneCyc = -1;
        for (int c = TRACE + 1; c <= TRACE + 150; c++) begin
            @(negedge clk);
            if (bus.done) begin
                doneCyc = c;
                break;
            end
        end
        checkOutput("b2b_second_done", doneCyc, doneCyc, 117);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/ntt_sched.md
# ntt_sched

Sequencer that runs one pipelined butterfly/ALU unit over an N-point coefficient memory. Per command it issues either a full in-place Cooley-Tukey NTT (log2 N stages of N/2 butterflies) or a single elementwise add/multiply pass. For each operation it generates the read addresses, twiddle addresses and BFU mode, then replays the matching write-back addresses after the datapath latency. Between stages it drains the pipeline so that no stage reads a location before the previous stage has written it. It sits between the host command interface and the BFU plus its coefficient/twiddle RAMs.

## Interface
- `logn`, 8, log2 of transform size N; valid range 2..12.
- `bfu_lat`, 14, cycles from BFU input to registered `out0`/`out1` (3*dm+2 for dm=4).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low. This is the single clock domain.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  2  command: 00/01 = NTT butterfly schedule (value forwarded as BFU mode), 10 = elementwise add, 11 = elementwise mul.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse in DONE.
- `rd_en`  out  1  read strobe to both coefficient ports.
- `rd_addr0`, `rd_addr1`  out  logn each  read addresses; u comes from port 0, v from port 1.
- `tw_addr`  out  logn  twiddle ROM address, issued in the same cycle as `rd_en`.
- `bfu_mode`  out  2  latched `op`; constant while busy.
- `wr_en0`, `wr_addr0`  out  1 / logn  write strobe and address for `out0`.
- `wr_en1`, `wr_addr1`  out  1 / logn  write strobe and address for `out1`.

## Operation
- **Reset.** Every output resets to 0. State goes to IDLE. The write-replay pipeline is cleared, so no stale `wr_en` fires after reset, including a reset applied mid-operation.
- **IDLE.**
  - When `start`=1: latch `op` into `bfu_mode`, clear the stage counter `s` and the index counter `k`, then go to RUN.
  - `start` is ignored in every other state.
- **RUN, NTT mode (`op[1]`=0).** One butterfly is issued per cycle, k = 0..N/2-1.
  - d = N >> (s+1), g = k / d, j = k mod d.
  - `rd_addr0` = g·2d + j, `rd_addr1` = `rd_addr0` + d, `tw_addr` = (1<<s) + g.
  - After k = N/2-1, go to DRAIN.
- **RUN, elementwise mode (`op[1]`=1).** k = 0..N-1.
  - `rd_addr0` = `rd_addr1` = k (two operand banks), `tw_addr` = 0.
  - After k = N-1, go to DRAIN.
- **Write replay.**
  - A shift register of depth LAT = `bfu_lat`+1 (1 RAM read cycle + BFU latency) carries {valid, addr0, addr1}.
  - `wr_en0` = valid.
  - `wr_en1` = valid AND NTT mode.
  - Addresses are those issued LAT cycles earlier.
- **DRAIN.**
  - Lasts exactly LAT cycles (counter 0..LAT-1); `rd_en`=0.
  - Exit: if NTT mode and s < logn-1, increment s, clear k and return to RUN. Otherwise go to DONE.
- **DONE.** `done`=1 and `busy`=0 for one cycle, then IDLE.
- **Widths.** Address arithmetic is in logn bits. By construction no value exceeds N-1, so no wrap occurs. For `tw_addr`, (1<<s)+g ≤ 2^(s+1)-1 ≤ N-1.

## Timing
- **NTT command.**
  - `start` is sampled at cycle 0 and the first `rd_en` occurs at cycle 1.
  - Each stage occupies N/2 RUN cycles + LAT DRAIN cycles.
  - `done` is asserted at cycle 1 + logn·(N/2 + LAT).
- **Elementwise command.** `done` is asserted at cycle 1 + N + LAT.
- **Write timing.**
  - A read issued at cycle t produces its write strobe at cycle t+LAT.
  - The last write of a stage lands in the last DRAIN cycle, so the next stage's first read, one cycle later, sees the updated data. There is no bypass.
- **Back-to-back commands.** A `start` in the DONE cycle is ignored. A `start` in the following cycle (IDLE) is accepted.

## Test plan
- **NTT address sequence.** Parameters logn=3, bfu_lat=14 (LAT=15). Pulse `start` with `op`=00 at cycle 0. Require:
  - Stage 0, cycles 1–4: read pairs (0,4),(1,5),(2,6),(3,7), `tw_addr`=1,1,1,1.
  - Stage 1, cycles 20–23: (0,2),(1,3),(4,6),(5,7), `tw_addr`=2,2,3,3.
  - Stage 2, cycles 39–42: (0,1),(2,3),(4,5),(6,7), `tw_addr`=4,5,6,7.
  - `done` at cycle 58; `busy` high for cycles 1–57.
- **Write replay and data check.** Same NTT run. Require:
  - `wr_en0`/`wr_en1` high exactly at cycles 16–19, 35–38 and 54–57.
  - Write addresses equal the read addresses issued 15 cycles earlier.
  - Run against a BFU+RAM model with q=12289 and compare the result with a software NTT.
- **Elementwise multiply.** `op`=11. Require:
  - `rd_addr0`=`rd_addr1`=0..7 on cycles 1–8.
  - `wr_en0` on cycles 16–23, `wr_en1` never asserted.
  - `bfu_mode`=11 throughout; `done` at cycle 24.
- **Start while busy.** Pulse `start` with `op`=10 at cycle 10 of an NTT run. Require the NTT sequence and `bfu_mode`=00 to be unchanged, and no second command to run.
- **Reset mid-stage.** Drive `rst_n`=0 at cycle 25 of an NTT run. Require:
  - In the next cycle, all outputs are 0 and the block is in IDLE.
  - No `wr_en` fires afterwards.
  - A fresh `start` reproduces the first scenario exactly.
- **Back-to-back commands.** Pulse `start` in the DONE cycle (ignored), then again in the following cycle (accepted). Require the first `rd_en` exactly one cycle after acceptance.
